// File: rtl/imem_loader.sv
// Boot-time program loader: assembles big-endian 32-bit words from a byte stream,
// writes them to instruction memory from address 0 and sequences the CPU reset.
module imem_loader #(
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              imem_wren,
    output logic              cpu_rstd,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded,
    output logic [31:0]       checksum
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_WRITE   = 3'd2,
        S_RELEASE = 3'd3,
        S_RUN     = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(IMEM_DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d;
    logic [ADDR_W:0] words_q, words_d;
    logic [31:0]     sum_q, sum_d;
    logic [31:0]     shift_q, shift_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [ADDR_W:0] len_clamp_s;
    logic [ADDR_W:0] words_inc_s;
    logic            rx_ready_q, wren_q, rstd_q, busy_q, done_q;

    // Next-state and datapath update for the load sequence.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        words_d     = words_q;
        sum_d       = sum_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        len_clamp_s = (len > DEPTH_C) ? DEPTH_C : len;
        words_inc_s = words_q + ONE_C;
        case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    len_d   = len_clamp_s;
                    words_d = '0;
                    sum_d   = 32'd0;
                    cnt_d   = 2'd0;
                    if (len_clamp_s == '0) begin
                        state_d = S_RELEASE;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_RECV: begin
                if (rx_valid) begin
                    shift_d = {shift_q[23:0], rx_data};
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_RECV;
                    end
                end else begin
                    state_d = S_RECV;
                end
            end
            S_WRITE: begin
                words_d = words_inc_s;
                sum_d   = sum_q + shift_q;
                cnt_d   = 2'd0;
                if (words_inc_s == len_q) begin
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_RECV;
                end
            end
            S_RELEASE: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flags derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            words_q    <= '0;
            sum_q      <= 32'd0;
            shift_q    <= 32'd0;
            cnt_q      <= 2'd0;
            rx_ready_q <= 1'b0;
            wren_q     <= 1'b1;
            rstd_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            words_q    <= words_d;
            sum_q      <= sum_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            rx_ready_q <= (state_d == S_RECV);
            wren_q     <= (state_d != S_WRITE);
            rstd_q     <= (state_d == S_RUN);
            busy_q     <= (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_RELEASE);
            done_q     <= (state_d == S_RUN);
        end
    end

    assign rx_ready     = rx_ready_q;
    assign imem_waddr   = words_q[ADDR_W-1:0];
    assign imem_wdata   = shift_q;
    assign imem_wren    = wren_q;
    assign cpu_rstd     = rstd_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign words_loaded = words_q;
    assign checksum     = sum_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed steps with random images,
// checked against an image/checksum/timing model built from the stream rules.
module tb_imem_loader;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic          clk = 1'b0;
    logic          rst, start, rx_valid;
    logic [AW:0]   len;
    logic [7:0]    rx_data;
    logic          rx_ready, imem_wren, cpu_rstd, busy, done;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata, checksum;
    logic [AW:0]   words_loaded;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;
    int seen   = 0;

    logic [31:0] mem [DEPTH];
    int          wa_q[$];
    logic [31:0] wd_q[$];
    int          wc_q[$];
    logic [31:0] img_q[$];
    logic [7:0]  bytes_q[$];

    imem_loader #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .imem_wren(imem_wren),
        .cpu_rstd(cpu_rstd), .busy(busy), .done(done),
        .words_loaded(words_loaded), .checksum(checksum)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: capture every write the loader issues.
    always @(negedge clk) begin
        if (imem_wren === 1'b0) begin
            wa_q.push_back(int'(imem_waddr));
            wd_q.push_back(imem_wdata);
            wc_q.push_back(cyc);
            mem[imem_waddr] = imem_wdata;
            chk("ready_low_in_write", 64'(rx_ready), 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic assemble();
        img_q.delete();
        for (int i = 0; i < bytes_q.size() / 4; i++)
            img_q.push_back({bytes_q[4*i], bytes_q[4*i+1], bytes_q[4*i+2], bytes_q[4*i+3]});
    endtask

    task automatic make_image(input int n);
        bytes_q.delete();
        for (int i = 0; i < 4 * n; i++) bytes_q.push_back(8'($urandom_range(0, 255)));
        assemble();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_wren"}, 64'(imem_wren), 64'd1);
        chk({tag, "_waddr"}, 64'(imem_waddr), 64'd0);
        chk({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
        chk({tag, "_cpu_rstd"}, 64'(cpu_rstd), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_words"}, 64'(words_loaded), 64'd0);
        chk({tag, "_checksum"}, 64'(checksum), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge of cycle T+1.
    task automatic do_start(input int l);
        start = 1'b1;
        len   = l[AW:0];
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        t0    = cyc;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_rstd_low", 64'(cpu_rstd), 64'd0);
        chk("start_done_low", 64'(done), 64'd0);
        chk("start_words_clr", 64'(words_loaded), 64'd0);
        chk("start_sum_clr", 64'(checksum), 64'd0);
        chk("start_ready", 64'(rx_ready), (l == 0) ? 64'd0 : 64'd1);
    endtask

    // mode 0: valid always; 1: valid toggles; 2: random. Optional ignored start pulse.
    task automatic stream(input int n, input int mode, input int pulse_at);
        int   idx = 0;
        int   guard = 0;
        logic v;
        logic xfer;
        logic pulsed = 1'b0;
        while (idx < n && guard < 6 * n + 40) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            rx_valid = v;
            rx_data  = bytes_q[idx];
            if (idx == pulse_at && !pulsed) begin
                start  = 1'b1;
                len    = 9'd3;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            xfer = v && (rx_ready === 1'b1);
            @(posedge clk);
            @(negedge clk);
            if (xfer) idx++;
            guard++;
        end
        start    = 1'b0;
        rx_valid = 1'b0;
        chk("stream_bytes_taken", 64'(idx), 64'(n));
    endtask

    task automatic wait_done(input int budget, output int at);
        int   g = 0;
        logic last_busy = 1'b0;
        logic last_rstd = 1'b1;
        while (done !== 1'b1 && g < budget) begin
            last_busy = busy;
            last_rstd = cpu_rstd;
            @(negedge clk);
            g++;
        end
        at = cyc;
        chk("done_reached", 64'(done), 64'd1);
        chk("done_rstd_high", 64'(cpu_rstd), 64'd1);
        chk("release_busy", 64'(last_busy), 64'd1);
        chk("release_rstd_low", 64'(last_rstd), 64'd0);
    endtask

    task automatic check_load(input int n, input bit timed);
        logic [31:0] s = 32'd0;
        foreach (img_q[i]) if (i < n) s += img_q[i];
        chk("write_count", 64'(wa_q.size()), 64'(n));
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            chk("write_addr", 64'(wa_q[i]), 64'(i));
            chk("write_data", 64'(wd_q[i]), 64'(img_q[i]));
            if (timed) chk("write_cycle", 64'(wc_q[i]), 64'(t0 + 5 * i + 4));
        end
        chk("words_loaded", 64'(words_loaded), 64'(n));
        chk("checksum", 64'(checksum), 64'(s));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; rx_data = 8'h00; rx_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_ready", 64'(rx_ready), 64'd0);
        end
        chk("idle_no_write", 64'(wa_q.size()), 64'd0);
        rx_valid = 1'b0;

        // Two-word image, back-to-back bytes.
        bytes_q = {8'h04, 8'h21, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h28};
        assemble();
        do_start(2);
        stream(8, 0, -1);
        wait_done(40, seen);
        chk("two_done_cycle", 64'(seen), 64'(t0 + 11));
        check_load(2, 1'b1);
        chk("two_w0", 64'(mem[0]), 64'h04210001);
        chk("two_w1", 64'(mem[1]), 64'h00000028);
        chk("two_sum", 64'(checksum), 64'h04210029);
        rx_valid = 1'b1; rx_data = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("run_ignores_bytes", 64'(rx_ready), 64'd0);
        end
        rx_valid = 1'b0;
        chk("run_no_extra_write", 64'(wa_q.size()), 64'd2);

        // Same image with toggling valid, reloaded from RUN.
        mem[0] = 32'd0; mem[1] = 32'd0;
        do_start(2);
        stream(8, 1, -1);
        wait_done(40, seen);
        check_load(2, 1'b0);
        chk("gap_w0", 64'(mem[0]), 64'h04210001);
        chk("gap_w1", 64'(mem[1]), 64'h00000028);

        // Random image, random gaps, start pulse mid-load must be ignored.
        make_image(5);
        do_start(5);
        stream(20, 2, 6);
        wait_done(60, seen);
        check_load(5, 1'b0);

        // Zero-length load.
        do_start(0);
        @(negedge clk);
        chk("len0_rstd", 64'(cpu_rstd), 64'd1);
        chk("len0_done", 64'(done), 64'd1);
        chk("len0_no_write", 64'(wa_q.size()), 64'd0);

        // Oversized length clamps to the full memory.
        make_image(DEPTH);
        do_start(300);
        stream(4 * DEPTH, 0, -1);
        wait_done(40, seen);
        chk("clamp_done_cycle", 64'(seen), 64'(t0 + 5 * DEPTH + 1));
        check_load(DEPTH, 1'b1);

        // Reset in the middle of word 1, then a one-word reload.
        make_image(2);
        do_start(2);
        stream(7, 0, -1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        bytes_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
        assemble();
        do_start(1);
        stream(4, 0, -1);
        wait_done(40, seen);
        check_load(1, 1'b1);
        chk("reload_mem0", 64'(mem[0]), 64'hDEADBEEF);
        chk("reload_sum", 64'(checksum), 64'hDEADBEEF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
